mult_share_arb: RTL and testbench

MULT_SHARE_ARB -- requirements
Module: mult_share_arb

---
 rtl/mult_share_pkg.sv | 18 +
 rtl/mul_pipe.sv | 34 +++
 rtl/mult_share_arb.sv | 111 +++++++++++
 tb/tb_mult_share_arb.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_share_pkg.sv
// Shared constants and the result-tag type for the shared-multiplier arbiter.
// The tag travels alongside each product so the result can be routed to its owner.
package mult_share_pkg;

    localparam int N_REQ_DEF   = 4;
    localparam int MUL_LAT_DEF = 3;
    localparam int A_W_DEF     = 18;
    localparam int B_W_DEF     = 8;

    // Owner index width; the arbiter supports up to 2**OWNER_W requesters.
    localparam int OWNER_W = $clog2(N_REQ_DEF);

    typedef struct packed {
        logic               valid;
        logic [OWNER_W-1:0] owner;
    } tag_t;

endpackage

// File: rtl/mul_pipe.sv
// Unsigned A x B multiplier with MUL_LAT register stages and no handshake.
// All stages sit after the multiply so synthesis can retime them into the array.
module mul_pipe #(
    parameter int A_W     = 18,
    parameter int B_W     = 8,
    parameter int MUL_LAT = 3
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    output logic [A_W+B_W-1:0] p
);

    localparam int P_W = A_W + B_W;

    logic [P_W-1:0] stage_q [MUL_LAT];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int k = 0; k < MUL_LAT; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q[0] <= P_W'(a) * P_W'(b);
            for (int k = 1; k < MUL_LAT; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign p = stage_q[MUL_LAT-1];

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin arbiter sharing one pipelined multiplier among N_REQ requesters.
// Handshake: a transfer on requester i happens in a cycle where req_valid[i] && req_ready[i].
module mult_share_arb
    import mult_share_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int A_W     = A_W_DEF,
    parameter int B_W     = B_W_DEF
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         en,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ*A_W-1:0]         req_a,
    input  logic [N_REQ*B_W-1:0]         req_b,
    output logic [N_REQ-1:0]             res_valid,
    output logic [A_W+B_W-1:0]           res_p,
    output logic [$clog2(MUL_LAT+1)-1:0] inflight
);

    localparam int IDX_W = OWNER_W;
    localparam int IF_W  = $clog2(MUL_LAT+1);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] cand_idx;
    logic             xfer;
    logic [N_REQ-1:0] grant;
    int               cand;
    logic [A_W-1:0]   sel_a;
    logic [B_W-1:0]   sel_b;
    tag_t             tag_q [MUL_LAT];
    tag_t             tail;

    // Search upward from ptr, wrapping at N_REQ; the first valid requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        xfer      = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        if (en && aresetn) begin
            for (int i = 0; i < N_REQ; i++) begin
                cand = int'(ptr) + i;
                if (cand >= N_REQ) begin
                    cand = cand - N_REQ;
                end
                cand_idx = IDX_W'(cand);
                if (!xfer && req_valid[cand_idx]) begin
                    xfer            = 1'b1;
                    grant_idx       = cand_idx;
                    grant[cand_idx] = 1'b1;
                end
            end
        end
    end

    assign req_ready = grant;

    // Idle cycles feed zeros so the multiplier does not toggle on stale operands.
    assign sel_a = xfer ? req_a[int'(grant_idx)*A_W +: A_W] : '0;
    assign sel_b = xfer ? req_b[int'(grant_idx)*B_W +: B_W] : '0;

    mul_pipe #(
        .A_W     (A_W),
        .B_W     (B_W),
        .MUL_LAT (MUL_LAT)
    ) u_mul_pipe (
        .aclk    (aclk),
        .aresetn (aresetn),
        .a       (sel_a),
        .b       (sel_b),
        .p       (res_p)
    );

    assign tail = tag_q[MUL_LAT-1];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ptr      <= '0;
            inflight <= '0;
            for (int k = 0; k < MUL_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0].valid <= xfer;
            tag_q[0].owner <= grant_idx;
            for (int k = 1; k < MUL_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
            if (xfer) begin
                ptr <= (grant_idx == IDX_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
            end
            case ({xfer, tail.valid})
                2'b10:   inflight <= inflight + IF_W'(1);
                2'b01:   inflight <= inflight - IF_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    always_comb begin
        res_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            res_valid[i] = tail.valid && (tail.owner == IDX_W'(i));
        end
    end

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb: grant order, latency, operand extremes,
// enable gating and reset discard, with a result scoreboard on every cycle.
module tb_mult_share_arb;

    localparam int N_REQ   = 4;
    localparam int MUL_LAT = 3;
    localparam int A_W     = 18;
    localparam int B_W     = 8;
    localparam int P_W     = A_W + B_W;
    localparam int IF_W    = $clog2(MUL_LAT+1);
    localparam int SB_W    = N_REQ + P_W;

    logic                 aclk = 1'b0;
    logic                 aresetn;
    logic                 en;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ*A_W-1:0] req_a;
    logic [N_REQ*B_W-1:0] req_b;
    logic [N_REQ-1:0]     res_valid;
    logic [P_W-1:0]       res_p;
    logic [IF_W-1:0]      inflight;

    int              n_cmp = 0;
    int              n_err = 0;
    logic [SB_W-1:0] exp_q[$];
    logic [SB_W-1:0] sb_e;

    mult_share_arb #(
        .N_REQ   (N_REQ),
        .MUL_LAT (MUL_LAT),
        .A_W     (A_W),
        .B_W     (B_W)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .en        (en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_p     (res_p),
        .inflight  (inflight)
    );

    // Clock / reset
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        @(negedge aclk);
    endtask

    task automatic drain(input int n);
        repeat (n) begin
            tick();
            settle();
        end
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*A_W +: A_W] = A_W'(a);
        req_b[i*B_W +: B_W] = B_W'(b);
    endtask

    task automatic expect_grant(input string tag, input logic [N_REQ-1:0] exp_ready, input int prod);
        check(tag, 32'(req_ready), 32'(exp_ready));
        if (exp_ready != '0) begin
            exp_q.push_back({exp_ready, P_W'(prod)});
        end
    endtask

    // Scoreboard: every result strobe must match the oldest expected transfer
    always @(negedge aclk) begin
        if (aresetn === 1'b1 && res_valid !== '0) begin
            if (exp_q.size() == 0) begin
                check("res_unexpected", 32'(res_valid), 32'd0);
            end else begin
                sb_e = exp_q.pop_front();
                check("res_owner", 32'(res_valid), 32'(sb_e[SB_W-1 -: N_REQ]));
                check("res_p", 32'(res_p), 32'(sb_e[P_W-1:0]));
            end
        end
    end

    int prod_tab [N_REQ];

    initial begin
        aresetn   = 1'b0;
        en        = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        repeat (2) @(posedge aclk);
        settle();
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_inflight", 32'(inflight), 32'd0);
        check("rst_res_p", 32'(res_p), 32'd0);

        // Single request: latency and inflight profile
        tick();
        aresetn   = 1'b1;
        set_op(0, 3, 5);
        req_valid = 4'b0001;
        settle();
        expect_grant("t1_ready", 4'b0001, 15);
        tick();
        req_valid = '0;
        settle();
        check("t1_inflight_t1", 32'(inflight), 32'd1);
        check("t1_res_valid_t1", 32'(res_valid), 32'd0);
        tick();
        settle();
        check("t1_inflight_t2", 32'(inflight), 32'd1);
        check("t1_res_valid_t2", 32'(res_valid), 32'd0);
        tick();
        settle();
        check("t1_inflight_t3", 32'(inflight), 32'd1);
        check("t1_res_valid_t3", 32'(res_valid), 32'd1);
        check("t1_res_p_t3", 32'(res_p), 32'd15);
        tick();
        settle();
        check("t1_inflight_t4", 32'(inflight), 32'd0);

        // Maximum operands on requester 1 (ptr is now 1)
        tick();
        set_op(1, 262143, 255);
        req_valid = 4'b0010;
        settle();
        expect_grant("t2_ready", 4'b0010, 66846465);
        tick();
        req_valid = '0;
        settle();
        drain(1);
        tick();
        settle();
        check("t2_res_p", 32'(res_p), 32'd66846465);
        drain(1);

        // Requesters 1 and 3 with ptr=2: grants 3, 1, 3 across the wrap
        tick();
        set_op(1, 7, 9);
        set_op(3, 100, 200);
        req_valid = 4'b1010;
        settle();
        expect_grant("t3_g0", 4'b1000, 20000);
        tick();
        settle();
        expect_grant("t3_g1", 4'b0010, 63);
        tick();
        settle();
        expect_grant("t3_g2", 4'b1000, 20000);
        tick();
        req_valid = '0;
        settle();
        drain(3);

        // All four valid from ptr=0: rotate 0,1,2,3,0,1 back to back
        prod_tab = '{22, 36, 52, 70};
        tick();
        for (int i = 0; i < N_REQ; i++) begin
            set_op(i, 11 + i, 2 + i);
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            settle();
            expect_grant("t4_rr", 4'(1 << (k % N_REQ)), prod_tab[k % N_REQ]);
            if (k == 5) check("t4_inflight_max", 32'(inflight), 32'd3);
        end

        // Enable low for 5 cycles: no grants, results drain, ptr kept at 2
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 0) en = 1'b0;
            settle();
            check("t5_ready_off", 32'(req_ready), 32'd0);
            if (k == 4) check("t5_inflight_drained", 32'(inflight), 32'd0);
        end
        tick();
        en = 1'b1;
        settle();
        expect_grant("t5_resume", 4'b0100, 52);
        tick();
        req_valid = '0;
        settle();
        drain(3);

        // Reset with three operations in flight (ptr is 3 before the burst)
        tick();
        req_valid = 4'b1111;
        settle();
        expect_grant("t6_g0", 4'b1000, 70);
        tick();
        settle();
        expect_grant("t6_g1", 4'b0001, 22);
        tick();
        settle();
        expect_grant("t6_g2", 4'b0010, 36);
        tick();
        req_valid = '0;
        settle();
        check("t6_inflight_pre", 32'(inflight), 32'd3);
        #1;
        aresetn   = 1'b0;
        req_valid = 4'b1111;
        #1;
        exp_q.delete();
        check("t6_rst_inflight", 32'(inflight), 32'd0);
        check("t6_rst_res_valid", 32'(res_valid), 32'd0);
        check("t6_rst_ready", 32'(req_ready), 32'd0);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        settle();
        expect_grant("t6_ptr_zero", 4'b0001, 22);
        tick();
        req_valid = '0;
        settle();
        drain(5);

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
